// File: rtl/fd_prog_divider.sv
// Runtime-programmable integer clock divider.
// Divides iclk by D (2..2^WIDTH-1) and produces a registered divided clock
// oclk (high for ceil(D/2) cycles) plus a one-cycle otick strobe at each oclk
// rising edge. A new divisor is staged in a pending register and only takes
// effect at a period boundary, so the output never shows a runt pulse.
module fd_prog_divider #(
    parameter int unsigned          WIDTH       = 16,
    parameter logic [WIDTH-1:0]     DEFAULT_DIV = WIDTH'(2)
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             ien,
    input  logic [WIDTH-1:0] idiv,
    input  logic             iload,
    output logic             oclk,
    output logic             otick,
    output logic [WIDTH-1:0] odiv
);

    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

    // Divider state
    logic [WIDTH-1:0] cnt_q;       // position inside the current period, 0..D-1
    logic [WIDTH-1:0] div_q;       // divisor in effect (D)
    logic [WIDTH-1:0] pend_div_q;  // staged divisor (P)
    logic             pend_q;      // staged divisor waiting for the next wrap (F)
    logic             oclk_q;
    logic             otick_q;

    // Derived values
    logic [WIDTH-1:0] div_last;    // D-1, the count value on which a period wraps
    logic [WIDTH-1:0] high_len;    // ceil(D/2), length of the high phase
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] load_div;    // idiv with the illegal values 0 and 1 forced to 2
    logic             wrap;
    logic             fall;

    // Decode period boundaries and the clamped load value from the current state.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        div_last = div_q - WIDTH'(1);
        high_len = (div_q >> 1) + WIDTH'(div_q[0]);
        cnt_inc  = cnt_q + WIDTH'(1);
        wrap     = (cnt_q == div_last);
        fall     = (cnt_inc == high_len);
        load_div = idiv;
        if (idiv < MIN_DIV) begin
            load_div = MIN_DIV;
        end
    end

    // Counter, divided clock and tick strobe; the divisor swap happens on the wrap edge.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, which is what lets a load on a wrap edge defer cleanly.
    always_ff @(posedge iclk) begin
        if (irst) begin
            cnt_q   <= '0;
            oclk_q  <= 1'b0;
            otick_q <= 1'b0;
            div_q   <= DEFAULT_DIV;
        end else if (ien) begin
            if (wrap) begin
                cnt_q   <= '0;
                oclk_q  <= 1'b1;
                otick_q <= 1'b1;
                if (pend_q) begin
                    div_q <= pend_div_q;
                end
            end else begin
                cnt_q   <= cnt_inc;
                otick_q <= 1'b0;
                if (fall) begin
                    oclk_q <= 1'b0;
                end
            end
        end else begin
            otick_q <= 1'b0;
        end
    end

    // Pending-divisor staging: a load always wins over the clear done by a wrap,
    // so a load on the wrap edge survives and applies one period later.
    always_ff @(posedge iclk) begin
        if (irst) begin
            pend_q     <= 1'b0;
            pend_div_q <= DEFAULT_DIV;
        end else begin
            if (ien && wrap && pend_q) begin
                pend_q <= 1'b0;
            end
            if (iload) begin
                pend_div_q <= load_div;
                pend_q     <= 1'b1;
            end
        end
    end

    assign oclk  = oclk_q;
    assign otick = otick_q;
    assign odiv  = div_q;

endmodule

// File: tb/tb_fd_prog_divider.sv
// Directed bench for fd_prog_divider: reset state, first rise, period/duty at
// several divisors, mid-period and wrap-edge loads, clamping, the full-scale
// divisor, enable freeze and reset with a pending load.
module tb_fd_prog_divider;

    localparam int WIDTH = 16;

    logic             iclk = 1'b0;
    logic             irst;
    logic             ien;
    logic [WIDTH-1:0] idiv;
    logic             iload;
    logic             oclk;
    logic             otick;
    logic [WIDTH-1:0] odiv;

    int tests_run    = 0;
    int tests_failed = 0;

    fd_prog_divider #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (16'd2)
    ) dut (
        .iclk  (iclk),
        .irst  (irst),
        .ien   (ien),
        .idiv  (idiv),
        .iload (iload),
        .oclk  (oclk),
        .otick (otick),
        .odiv  (odiv)
    );

    always #5 iclk = ~iclk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Outputs are sampled and inputs driven on the falling edge.
    task automatic step();
        @(negedge iclk);
    endtask

    // Starting at the current sample, count high and low cycles of oclk until the
    // next otick, optionally issuing one load at sample index ld_at. Ends on the
    // tick sample, where odiv reflects any divisor applied by that wrap.
    task automatic measure(input string tag, input int exp_hi, input int exp_lo,
                           input logic [31:0] exp_div, input int ld_at,
                           input logic [WIDTH-1:0] ld_val, input int budget);
        int hi = 0;
        int lo = 0;
        int n  = 0;
        bit done = 0;
        while (!done) begin
            if (oclk) hi++; else lo++;
            iload = (n == ld_at);
            idiv  = ld_val;
            step();
            n++;
            if (otick) done = 1;
            else if (n >= budget) begin
                check({tag, "_timeout"}, 0, 1);
                done = 1;
            end
        end
        iload = 1'b0;
        check({tag, "_high"}, hi, exp_hi);
        check({tag, "_low"},  lo, exp_lo);
        check({tag, "_odiv"}, odiv, exp_div);
    endtask

    initial begin
        irst  = 1'b1;
        ien   = 1'b0;
        idiv  = '0;
        iload = 1'b0;
        step();
        step();
        check("rst_oclk",  oclk,  0);
        check("rst_otick", otick, 0);
        check("rst_odiv",  odiv,  2);

        // First rise lands on the second enabled edge at D=2.
        irst = 1'b0;
        ien  = 1'b1;
        step();
        check("edge1_oclk",  oclk,  0);
        check("edge1_otick", otick, 0);
        step();
        check("edge2_oclk",  oclk,  1);
        check("edge2_otick", otick, 1);
        measure("d2_a", 1, 1, 2, -1, '0, 10);
        measure("d2_b", 1, 1, 2, -1, '0, 10);

        // Divide by 3 then by 8.
        measure("ld3",  1, 1, 3,  0, 16'd3, 10);
        measure("d3",   2, 1, 3, -1, '0,    10);
        measure("ld8",  2, 1, 8,  0, 16'd8, 10);
        measure("d8",   4, 4, 8, -1, '0,    20);

        // At D=5 load 4 while cnt=1: current period stays 5.
        measure("ld5",    4, 4, 5,  0, 16'd5, 20);
        measure("d5_ld4", 3, 2, 4,  1, 16'd4, 20);
        // Load exactly on the wrap edge: the change waits one extra period.
        measure("d4_wrapld", 2, 2, 4, 3, 16'd6, 20);
        measure("d4_defer",  2, 2, 6, -1, '0,   20);

        // At D=6 freeze for 10 cycles starting at the top of the high phase.
        ien = 1'b0;
        step();
        check("frz_otick", otick, 0);
        check("frz_oclk1", oclk,  1);
        repeat (9) step();
        check("frz_oclk10",  oclk,  1);
        check("frz_otick10", otick, 0);
        ien = 1'b1;
        measure("d6_resume", 3, 3, 6, -1, '0, 20);

        // Clamping of 0 and 1 to 2.
        measure("ld0",    3, 3, 2,  0, 16'd0, 20);
        measure("d2_c",   1, 1, 7,  0, 16'd7, 10);
        measure("d7_ld1", 4, 3, 2,  1, 16'd1, 20);
        measure("d2_d",   1, 1, 2, -1, '0,    10);

        // Full-scale divisor, then load 7 during the long period.
        measure("ldffff", 1, 1, 16'hFFFF, 0, 16'hFFFF, 10);
        measure("dffff",  32768, 32767, 7, 0, 16'd7, 70000);

        // At D=7, stage a load of 3, then reset mid-period.
        step();
        step();
        iload = 1'b1;
        idiv  = 16'd3;
        step();
        iload = 1'b0;
        irst  = 1'b1;
        step();
        check("mrst_oclk",  oclk,  0);
        check("mrst_otick", otick, 0);
        check("mrst_odiv",  odiv,  2);
        irst = 1'b0;
        step();
        check("mrst_e1_oclk", oclk, 0);
        step();
        check("mrst_e2_otick", otick, 1);
        check("mrst_e2_odiv",  odiv,  2);
        measure("mrst_d2", 1, 1, 2, -1, '0, 10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fd_prog_divider.md
Name: fd_prog_divider

Overview:
- Runtime-programmable successor to the fixed divide-by-2 flip-flop divider.
- Divides `iclk` by an integer D in the range 2..2^WIDTH-1.
- Produces a registered divided clock `oclk` with duty high = ceil(D/2) input cycles.
- Also produces a one-cycle `otick` strobe at each `oclk` rising edge, for use as a clock enable by downstream logic in the same `iclk` domain.
- Divisor changes are glitch-free: they are applied only at a period boundary.

Parameters:
- WIDTH, 16: width of the divisor and of the internal counter.
- DEFAULT_DIV, 2: divisor loaded at reset. Must satisfy 2 <= DEFAULT_DIV <= 2^WIDTH-1.

Ports:
- iclk  in  1  system clock. All logic is on its rising edge.
- irst  in  1  synchronous, active-high reset.
- ien  in  1  count enable. When low, the divider freezes.
- idiv  in  WIDTH  requested divisor, sampled only when `iload`=1.
- iload  in  1  single-cycle strobe that captures `idiv` into the pending register.
- oclk  out  1  divided clock (registered).
- otick  out  1  one-`iclk`-cycle pulse coinciding with each `oclk` rising edge.
- odiv  out  WIDTH  divisor currently in effect (D).

Behaviour:
- Clocking: single clock `iclk`; reset `irst` is synchronous and active-high.
- Reset (irst=1 at a posedge) overrides all other inputs and sets:
  - cnt=0, oclk=0, otick=0;
  - D=DEFAULT_DIV, so odiv=DEFAULT_DIV;
  - pending flag=0.
- Reset mid-period: the period is abandoned and any pending load is discarded.
- Internal state: counter cnt over 0..D-1; pending divisor P; pending flag F.
- Enabled edge (ien=1, irst=0):
  - Wrap (cnt==D-1):
    - cnt<=0, oclk<=1, otick<=1;
    - if F=1 then D<=P and F<=0.
  - Otherwise:
    - cnt<=cnt+1, otick<=0;
    - if cnt+1==ceil(D/2) then oclk<=0, else oclk holds.
- Resulting waveform: period D cycles, high for ceil(D/2), low for floor(D/2).
- First `oclk` rise occurs D enabled edges after reset release.
- Disabled edge (ien=0): cnt, oclk, D and F hold; otick<=0.
- Load:
  - iload=1 at any non-reset edge sets P<=clamp(idiv) and F<=1, regardless of `ien`.
  - clamp: idiv values 0 and 1 become 2; all other values pass unchanged.
  - Several loads before a wrap: the last one wins.
  - Load on the same edge as a wrap: the wrap uses the old P/F state; the new value is captured and applies at the following wrap.
- A new D takes effect for the whole period that starts at the wrap edge. cnt is 0 at that point, so it can never exceed the new D-1, and there is no glitch or runt pulse.
- odiv updates on the same edge that D changes.
- All outputs are registered, with no combinational path from any input to any output.

Test Plan:
- Reset, then ien=1, no load → odiv=2; oclk toggles every cycle (1 high, 1 low); otick=1 on every other cycle, aligned with `oclk` rising; first rise on the 2nd enabled edge.
- iload with idiv=3, then hold → after the next wrap, period is 3 with oclk high 2 / low 1 and otick every 3rd cycle. Repeat with idiv=8: high 4 / low 4.
- Running at D=5, iload idiv=4 at cnt=1 → the current period completes at length 5, odiv changes to 4 at the wrap edge, subsequent periods are 4. Also: iload asserted exactly on a wrap edge → the change is deferred by one full period.
- iload idiv=0 and idiv=1 → odiv=2 after the next wrap. Also: idiv=16'hFFFF → period 65535, high 32768.
- At D=6, drop ien for 10 cycles mid-high-phase → oclk and cnt frozen, otick=0; after re-enable, remaining high cycles plus the full low phase total 6 enabled edges per period.
- At D=7 with a pending load, assert irst for 1 cycle mid-period → next cycle oclk=0, otick=0, odiv=DEFAULT_DIV, and the pending load is discarded (no change at the next wrap).
